mux_scan_seq: RTL and testbench
===============================

Name: mux_scan_seq

Overview:
- Upstream/downstream companion to the 4:1 two-bit selector.
- Drives the selector's S[1:0] and EN so that it scans channels 0..3 in order, then captures the selector's returned 2-bit Y into four per-channel holding registers.
- Supports single-frame and continuous scanning. Signals each completed frame with a one-cycle strobe.

Parameters:
- DIV, 4: dwell length per channel, in clk cycles. Legal range 1..256.
- CW, 8: width of the dwell counter. Must satisfy 2^CW >= DIV.

Ports:
- clk  in  1  single system clock; everything is updated on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  level-sampled request to begin a scan; acted on only in IDLE.
- cont  in  1  continuous mode; sampled at each frame end.
- abort  in  1  terminates a scan in progress.
- Y_in  in  2  selector output, fed back for capture.
- S  out  2  channel select to the selector.
- EN  out  1  selector enable.
- CH0, CH1, CH2, CH3  out  2 each  captured value for each channel.
- busy  out  1  high while in SCAN.
- frame_done  out  1  one-cycle pulse after CH3 is captured.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, S=0, EN=0, busy=0, frame_done=0, CH0..CH3=0, cnt=0.
  - Reset overrides every other input, including mid-scan. Partial frames are discarded.
- States: IDLE and SCAN only. Registered outputs; no combinational path from any input to any output.
- IDLE:
  - start=1 and abort=0 -> next state SCAN; S<=0, EN<=1, busy<=1, cnt<=0.
  - Otherwise hold; EN stays 0.
- SCAN, each edge with abort=0:
  - If cnt != DIV-1: cnt<=cnt+1.
  - If cnt == DIV-1:
    - CH[S]<=Y_in; cnt<=0.
    - If S<3: S<=S+1.
    - If S==3: frame_done<=1 for exactly one cycle.
      - cont=1: S<=0, stay in SCAN.
      - cont=0: state<=IDLE, EN<=0, busy<=0, S<=0.
- Capture timing: Y_in is sampled on the last cycle of each dwell, giving DIV-1 cycles of settle after S changes.
- Latency: start accepted at edge t -> CH0 at t+DIV, CH3 and frame_done at t+4*DIV. frame_done is visible during the cycle after t+4*DIV.
- DIV=1: one channel per cycle; each channel is captured on the edge after S selects it.
- abort=1 in SCAN:
  - Next state IDLE, EN<=0, S<=0, cnt<=0, busy<=0, no frame_done.
  - CHx values already captured are retained.
  - A capture due on the same edge is dropped.
- start while in SCAN is ignored (no restart).
- start and abort together in IDLE: abort wins, stay IDLE.
- cont changing mid-frame has no effect until the frame-end edge.
- S wrap-around 3->0 happens only in continuous mode; S never exceeds 3.
- frame_done clears on the following edge unconditionally.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=1'b0, SCAN=1'b1);
  - channel index constants CH_A=2'd0, CH_B=2'd1, CH_C=2'd2, CH_D=2'd3;
  - DIV default.
- One natural sub-module, scan_dwell_cnt: DIV counter with clear input and terminal-count output (cnt==DIV-1).
- The FSM, S counter and capture bank live in the top module.

Test Plan:
- Single frame, DIV=4, cont=0; Y_in forced to 2'd1/2'd2/2'd3/2'd0 whenever S=0/1/2/3; 1-cycle start at edge t:
  - CH0..CH3 = 1,2,3,0;
  - frame_done high only in the cycle after t+16;
  - EN and busy fall at t+16; S=0.
- Reset mid-scan: rst at t+6 -> next cycle all outputs 0, state IDLE. Y_in values captured before the reset are not retained.
- Abort at t+9 (S=2, cnt=0), DIV=4:
  - CH0 and CH1 hold their new values; CH2 and CH3 unchanged;
  - no frame_done; EN=0 from t+9.
- Continuous mode, cont=1 for two frames:
  - frame_done pulses at t+16 and t+32;
  - S sequence 0,1,2,3,0,1,...;
  - EN held 1 throughout.
  - Drop cont to 0 during frame 2 -> IDLE after t+32.
- Edge cases:
  - start while busy at t+5 -> no change to cnt or S.
  - start and abort together in IDLE -> stays IDLE.
  - DIV=1 -> S steps every cycle; frame_done at t+4.

Source files
------------

// File: rtl/mux_scan_seq_pkg.sv
// Shared definitions for the channel-scan sequencer.
//   state_t      : FSM state encoding (IDLE / SCAN)
//   CH_A..CH_D   : channel select codes driven on S
//   DIV_DEFAULT  : default dwell length per channel, in clk cycles
package mux_scan_seq_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam logic [1:0] CH_A = 2'd0;
   localparam logic [1:0] CH_B = 2'd1;
   localparam logic [1:0] CH_C = 2'd2;
   localparam logic [1:0] CH_D = 2'd3;

   localparam int DIV_DEFAULT = 4;

endpackage

// File: rtl/mux_scan_seq_dwell.sv
// Dwell counter for the channel-scan sequencer.
// Counts 0..DIV-1 while enabled, then wraps to 0. tc is high while the
// count sits on DIV-1, i.e. on the last cycle of a channel dwell.
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   clr  : synchronous clear to 0 (takes priority over en)
//   en   : advance the count
//   tc   : terminal count (cnt == DIV-1)
module scan_dwell_cnt
   import mux_scan_seq_pkg::*;
#(
   parameter int DIV = DIV_DEFAULT,
   parameter int CW  = 8
)(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [CW-1:0] TC_VAL = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   assign tc = (cnt == TC_VAL);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/mux_scan_seq.sv
// Channel-scan sequencer for a 4:1 two-bit selector.
// Steps S through channels 0..3, dwelling DIV cycles on each, and captures
// the returned Y_in into CH0..CH3 on the last cycle of each dwell. Runs one
// frame, or back-to-back frames while cont is high at frame end.
//   clk, rst        : clock, synchronous active-high reset
//   start           : begin a scan (IDLE only; abort has priority)
//   cont            : continuous mode, sampled at frame end
//   abort           : stop a scan in progress, dropping any capture due
//   Y_in            : selector output fed back for capture
//   S, EN           : selector channel select and enable
//   CH0..CH3        : captured value per channel
//   busy            : high while scanning
//   frame_done      : one-cycle pulse after CH3 is captured
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | selector disabled, S parked at 0, waiting for start
// SCAN  | selector enabled, dwelling on channel S, capturing at dwell end
module mux_scan_seq
   import mux_scan_seq_pkg::*;
#(
   parameter int DIV = DIV_DEFAULT,
   parameter int CW  = 8
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       cont,
   input  logic       abort,
   input  logic [1:0] Y_in,
   output logic [1:0] S,
   output logic       EN,
   output logic [1:0] CH0,
   output logic [1:0] CH1,
   output logic [1:0] CH2,
   output logic [1:0] CH3,
   output logic       busy,
   output logic       frame_done
);

   state_t state;
   logic   tc;
   logic   dwell_clr;
   logic   dwell_en;

   // Holding the counter clear outside SCAN guarantees every scan starts
   // its first dwell from zero, whatever ended the previous one.
   assign dwell_clr = (state == IDLE) || abort;
   assign dwell_en  = (state == SCAN);

   scan_dwell_cnt #(
      .DIV (DIV),
      .CW  (CW)
   ) u_dwell (
      .clk (clk),
      .rst (rst),
      .clr (dwell_clr),
      .en  (dwell_en),
      .tc  (tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         S          <= CH_A;
         EN         <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         CH0        <= 2'd0;
         CH1        <= 2'd0;
         CH2        <= 2'd0;
         CH3        <= 2'd0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  state <= SCAN;
                  S     <= CH_A;
                  EN    <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            SCAN: begin
               if (abort) begin
                  state <= IDLE;
                  S     <= CH_A;
                  EN    <= 1'b0;
                  busy  <= 1'b0;
               end else if (tc) begin
                  case (S)
                     CH_A:    CH0 <= Y_in;
                     CH_B:    CH1 <= Y_in;
                     CH_C:    CH2 <= Y_in;
                     default: CH3 <= Y_in;
                  endcase
                  if (S == CH_D) begin
                     frame_done <= 1'b1;
                     S          <= CH_A;
                     if (!cont) begin
                        state <= IDLE;
                        EN    <= 1'b0;
                        busy  <= 1'b0;
                     end
                  end else begin
                     S <= S + 2'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_scan_seq.sv
module tb_mux_scan_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic cont = 1'b0;
   logic abort = 1'b0;
   logic [1:0] yv [2];

   logic [1:0]       s_o    [2];
   logic             en_o   [2];
   logic             busy_o [2];
   logic             fd_o   [2];
   logic [3:0][1:0]  ch_o   [2];

   always #5 clk = ~clk;

   mux_scan_seq #(.DIV(4), .CW(8)) u_div4 (
      .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
      .Y_in(yv[0]), .S(s_o[0]), .EN(en_o[0]),
      .CH0(ch_o[0][0]), .CH1(ch_o[0][1]), .CH2(ch_o[0][2]), .CH3(ch_o[0][3]),
      .busy(busy_o[0]), .frame_done(fd_o[0])
   );

   mux_scan_seq #(.DIV(1), .CW(8)) u_div1 (
      .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
      .Y_in(yv[1]), .S(s_o[1]), .EN(en_o[1]),
      .CH0(ch_o[1][0]), .CH1(ch_o[1][1]), .CH2(ch_o[1][2]), .CH3(ch_o[1][3]),
      .busy(busy_o[1]), .frame_done(fd_o[1])
   );

   // Reference model: a scan is a position 0..4*DIV-1 within the frame;
   // the channel is position/DIV and a capture happens when the position
   // is the last one of its dwell.
   int         div_of [2] = '{4, 1};
   int         m_pos  [2];
   bit         m_busy [2];
   bit         m_fd   [2];
   logic [1:0] m_ch   [2][4];
   logic [7:0] q0 [$];
   logic [7:0] q1 [$];

   int checks = 0;
   int failures = 0;
   bit ymode = 1'b1;
   logic [1:0] ymap [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

   function automatic logic [1:0] exp_s(int k);
      return m_busy[k] ? 2'(m_pos[k] / div_of[k]) : 2'd0;
   endfunction

   task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s div=%0d t=%0t actual=%0h required=%0h", name, div_of[k], $time, act, exp);
      end
   endtask

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         m_fd[k] = 1'b0;
         if (rst) begin
            m_busy[k] = 1'b0;
            m_pos[k]  = 0;
            for (int c = 0; c < 4; c++) m_ch[k][c] = 2'd0;
         end else if (!m_busy[k]) begin
            if (start && !abort) begin
               m_busy[k] = 1'b1;
               m_pos[k]  = 0;
            end
         end else if (abort) begin
            m_busy[k] = 1'b0;
            m_pos[k]  = 0;
         end else begin
            int d, ch;
            d  = div_of[k];
            ch = m_pos[k] / d;
            if (m_pos[k] % d == d - 1) begin
               m_ch[k][ch] = yv[k];
               if (ch == 3) begin
                  m_fd[k] = 1'b1;
                  if (k == 0) q0.push_back({m_ch[k][3], m_ch[k][2], m_ch[k][1], m_ch[k][0]});
                  else        q1.push_back({m_ch[k][3], m_ch[k][2], m_ch[k][1], m_ch[k][0]});
                  if (!cont) m_busy[k] = 1'b0;
               end
            end
            m_pos[k] = m_busy[k] ? (m_pos[k] + 1) % (4 * d) : 0;
         end
      end
   end

   // Monitor: per-cycle output checks, plus a frame scoreboard popped on
   // every frame_done the DUT presents.
   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("S", k, 8'(s_o[k]), 8'(exp_s(k)));
         chk("EN", k, 8'(en_o[k]), 8'(m_busy[k]));
         chk("busy", k, 8'(busy_o[k]), 8'(m_busy[k]));
         chk("frame_done", k, 8'(fd_o[k]), 8'(m_fd[k]));
         for (int c = 0; c < 4; c++)
            chk($sformatf("CH%0d", c), k, 8'(ch_o[k][c]), 8'(m_ch[k][c]));
         if (fd_o[k] === 1'b1) begin
            logic [7:0] e;
            bit empty;
            empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
               chk("frame_unexpected", k, 8'd1, 8'd0);
            end else begin
               e = (k == 0) ? q0.pop_front() : q1.pop_front();
               chk("frame_capture", k, {ch_o[k][3], ch_o[k][2], ch_o[k][1], ch_o[k][0]}, e);
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      for (int k = 0; k < 2; k++)
         yv[k] = ymode ? ymap[exp_s(k)] : 2'($urandom_range(0, 3));
   endtask

   initial begin
      yv[0] = 2'd0;
      yv[1] = 2'd0;
      repeat (3) tick();
      rst = 1'b0;

      // single frame with a start pulse while busy
      start = 1'b1; tick(); start = 1'b0;
      repeat (5) tick();
      start = 1'b1; tick(); start = 1'b0;
      repeat (16) tick();

      // reset mid-scan
      start = 1'b1; tick(); start = 1'b0;
      repeat (5) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      repeat (3) tick();

      // random-data frame, then an aborted frame with mapped data
      ymode = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      repeat (18) tick();
      ymode = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      repeat (8) tick();
      abort = 1'b1; tick(); abort = 1'b0;
      repeat (4) tick();

      // start together with abort in IDLE
      start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
      repeat (3) tick();

      // continuous for two frames, cont dropped during the second
      cont = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      repeat (20) tick();
      cont = 1'b0;
      repeat (16) tick();

      // randomized traffic
      ymode = 1'b0;
      repeat (500) begin
         tick();
         start = ($urandom_range(0, 7) == 0);
         cont  = $urandom_range(0, 1) != 0;
         abort = ($urandom_range(0, 29) == 0);
         rst   = ($urandom_range(0, 149) == 0);
      end
      rst = 1'b0; start = 1'b0; abort = 1'b0; cont = 1'b0;
      repeat (40) tick();

      chk("frames_pending", 0, 8'(q0.size()), 8'd0);
      chk("frames_pending", 1, 8'(q1.size()), 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
